alu_iter: RTL and testbench
===========================

ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits; legal values are 8 to 64, powers of two.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 The block SHALL have port Start, input, 1 bit: request to begin an operation on SrcA/SrcB/ALUControl.
REQ-005 The block SHALL have port ALUControl, input, 4 bits: operation select.
REQ-006 The block SHALL have port SrcA, input, WIDTH bits: operand A.
REQ-007 The block SHALL have port SrcB, input, WIDTH bits: operand B.
REQ-008 The block SHALL have port ALUResult, output, WIDTH bits: registered result.
REQ-009 The block SHALL have port Zero, output, 1 bit: high when ALUResult == 0, combinational from ALUResult.
REQ-010 The block SHALL have port Busy, output, 1 bit: an iterative operation is in progress.
REQ-011 The block SHALL have port Done, output, 1 bit: one-cycle pulse; ALUResult is valid in that cycle.

Function
REQ-012 Encodings SHALL be: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT (signed), 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA, 1010 MUL (low WIDTH bits), 1011 MULHU (high WIDTH bits, unsigned), 1100 DIV, 1101 DIVU, 1110 REM, 1111 REMU.
REQ-013 ADD/SUB SHALL wrap modulo 2^WIDTH; SLT/SLTU SHALL return 1 or 0 zero-extended; shifts SHALL use SrcB[log2(WIDTH)-1:0] as the amount and ignore the upper bits.
REQ-014 The FSM SHALL have the states IDLE, MUL, DIV and DONE.
REQ-015 Start SHALL be accepted only in IDLE; Start in any other state SHALL be ignored with no effect on the operation in progress.
REQ-016 Single-cycle ops (0000-1001) accepted at edge k SHALL load ALUResult at edge k and assert Done for the cycle after edge k; Busy SHALL stay low; state IDLE->DONE->IDLE.
REQ-017 On acceptance, operands and ALUControl SHALL be captured; later changes on the inputs SHALL not affect the result.
REQ-018 MUL/MULHU SHALL use unsigned shift-add, one multiplier bit per cycle, for WIDTH iterations (state MUL).
REQ-019 DIV/DIVU/REM/REMU SHALL use restoring division, one quotient bit per cycle, for WIDTH iterations (state DIV).
REQ-020 Signed division SHALL operate on magnitudes; the quotient SHALL be negated when operand signs differ, and the remainder SHALL take the sign of SrcA.
REQ-021 Iterative ops accepted at edge k SHALL raise Busy from edge k to edge k+WIDTH, load ALUResult at edge k+WIDTH, and assert Done for the cycle after edge k+WIDTH; the total latency is WIDTH+1 cycles.
REQ-022 Divide by zero SHALL give DIV/DIVU quotient = all ones and REM/REMU = SrcA, with the same latency and no exception.
REQ-023 Signed overflow (SrcA = most negative value, SrcB = -1) SHALL give DIV = SrcA and REM = 0.
REQ-024 ALUResult SHALL hold its value between Done pulses.
REQ-025 From DONE the FSM SHALL return to IDLE unconditionally; a Start in the Done cycle SHALL be ignored, so back-to-back accepts are at least 2 cycles apart.

Reset
REQ-026 When reset is high at an edge, in any state including mid-iteration, the block SHALL set state IDLE, ALUResult 0, Busy 0 and Done 0, and Zero SHALL read 1.
REQ-027 A Start coincident with reset SHALL be ignored.
REQ-028 A partial iterative result SHALL never appear on ALUResult after reset.

Verification
REQ-029 With WIDTH=32, SUB 5-7 -> Done one cycle later, ALUResult 0xFFFFFFFE, Zero 0; then SUB 7-7 -> ALUResult 0, Zero 1.
REQ-030 With WIDTH=32, SRA 0x80000000 by SrcB=0x24 -> shift amount 4, ALUResult 0xF8000000; SLTU 1 vs 0xFFFFFFFF -> 1; SLT 1 vs 0xFFFFFFFF -> 0.
REQ-031 With WIDTH=32, MUL 0xFFFFFFFF x 0xFFFFFFFF -> Busy for 32 cycles, Done in cycle 33, ALUResult 0x00000001; MULHU with the same operands -> 0xFFFFFFFE.
REQ-032 With WIDTH=32, DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 9/0 -> 0xFFFFFFFF; REMU 9/0 -> 9; DIV 0x80000000/-1 -> 0x80000000, REM -> 0.
REQ-033 Start while Busy (new operands) -> ignored, the original result is delivered; reset asserted at iteration 10 of DIVU -> next cycle Busy 0, Done 0, ALUResult 0, and a new ADD then completes normally.
REQ-034 With WIDTH=8, MUL 0x10 x 0x10 -> Done after 9 cycles, ALUResult 0x00; MULHU with the same operands -> 0x01.

Source files
------------

// File: rtl/alu_iter.sv
// Iterative ALU: single-cycle logic/shift/compare ops, shift-add MUL and restoring DIV; Done pulses 1 cycle after accept (WIDTH+1 for MUL/DIV).
// No backpressure: Start is honoured only in IDLE and ignored while busy or in the Done cycle.
module alu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             Busy,
    output logic             Done
);

    localparam int SW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic [2*WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   srca_q, srca_d;
    logic [SW-1:0]      cnt_q, cnt_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   res_q, res_d;

    logic [SW-1:0]      shamt;
    logic [WIDTH-1:0]   quick_res;
    logic               sdiv, a_neg, b_neg;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_hi;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_sh, div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;
    logic [WIDTH-1:0]   q_fin, r_fin;
    logic               last;

    assign shamt = SrcB[SW-1:0];

    always_comb begin
        quick_res = '0;
        case (ALUControl)
            4'b0000: quick_res = SrcA + SrcB;
            4'b0001: quick_res = SrcA - SrcB;
            4'b0010: quick_res = SrcA & SrcB;
            4'b0011: quick_res = SrcA | SrcB;
            4'b0100: quick_res = SrcA ^ SrcB;
            4'b0101: quick_res = {{(WIDTH-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
            4'b0110: quick_res = {{(WIDTH-1){1'b0}}, SrcA < SrcB};
            4'b0111: quick_res = SrcA << shamt;
            4'b1000: quick_res = SrcA >> shamt;
            4'b1001: quick_res = $signed(SrcA) >>> shamt;
            default: quick_res = '0;
        endcase
    end

    // Signed DIV/REM run on magnitudes; signs are fixed up on the final step.
    assign sdiv  = (ALUControl == 4'b1100) || (ALUControl == 4'b1110);
    assign a_neg = sdiv & SrcA[WIDTH-1];
    assign b_neg = sdiv & SrcB[WIDTH-1];
    assign abs_a = a_neg ? -SrcA : SrcA;
    assign abs_b = b_neg ? -SrcB : SrcB;

    // Shift-add step: work holds {partial high, remaining multiplier bits}.
    assign mul_hi   = {1'b0, work_q[2*WIDTH-1:WIDTH]} + {1'b0, (work_q[0] ? opnd_q : '0)};
    assign mul_next = {mul_hi, work_q[WIDTH-1:1]};

    // Restoring step: work holds {partial remainder, dividend/quotient bits}.
    assign div_sh   = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, opnd_q};
    assign div_ge   = ~div_diff[WIDTH];
    assign div_next = {(div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0]), work_q[WIDTH-2:0], div_ge};
    assign q_fin    = div_next[WIDTH-1:0];
    assign r_fin    = div_next[2*WIDTH-1:WIDTH];

    assign last = (cnt_q == SW'(WIDTH-1));

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        work_d  = work_q;
        opnd_d  = opnd_q;
        srca_d  = srca_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    op_d   = ALUControl;
                    srca_d = SrcA;
                    cnt_d  = '0;
                    if (ALUControl[3:1] == 3'b101) begin
                        work_d  = {{WIDTH{1'b0}}, SrcA};
                        opnd_d  = SrcB;
                        state_d = S_MUL;
                    end else if (ALUControl[3:2] == 2'b11) begin
                        work_d  = {{WIDTH{1'b0}}, abs_a};
                        opnd_d  = abs_b;
                        qneg_d  = a_neg ^ b_neg;
                        rneg_d  = a_neg;
                        dz_d    = (SrcB == '0);
                        state_d = S_DIV;
                    end else begin
                        res_d   = quick_res;
                        state_d = S_DONE;
                    end
                end
            end
            S_MUL: begin
                work_d = mul_next;
                cnt_d  = cnt_q + 1'b1;
                if (last) begin
                    res_d   = op_q[0] ? mul_next[2*WIDTH-1:WIDTH] : mul_next[WIDTH-1:0];
                    state_d = S_DONE;
                end
            end
            S_DIV: begin
                work_d = div_next;
                cnt_d  = cnt_q + 1'b1;
                if (last) begin
                    if (dz_q)
                        res_d = op_q[1] ? srca_q : '1;
                    else if (op_q[1])
                        res_d = rneg_q ? -r_fin : r_fin;
                    else
                        res_d = qneg_q ? -q_fin : q_fin;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            work_q  <= '0;
            opnd_q  <= '0;
            srca_q  <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            work_q  <= work_d;
            opnd_q  <= opnd_d;
            srca_q  <= srca_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            res_q   <= res_d;
        end
    end

    assign ALUResult = res_q;
    assign Zero      = (res_q == '0);
    assign Busy      = (state_q == S_MUL) || (state_q == S_DIV);
    assign Done      = (state_q == S_DONE);

endmodule

// File: tb/tb_alu_iter.sv
// Bench for alu_iter: 32-bit instance checked against an arithmetic reference model, 8-bit instance for small-width multiply/divide.
module tb_alu_iter;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [3:0]  ALUControl;
    logic [31:0] SrcA, SrcB, ALUResult;
    logic        Zero, Busy, Done;

    logic        start8;
    logic [3:0]  ctrl8;
    logic [7:0]  a8, b8, res8;
    logic        zero8, busy8, done8;

    int total = 0;
    int bad   = 0;

    alu_iter #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .Start(Start), .ALUControl(ALUControl),
        .SrcA(SrcA), .SrcB(SrcB), .ALUResult(ALUResult), .Zero(Zero),
        .Busy(Busy), .Done(Done)
    );

    alu_iter #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .Start(start8), .ALUControl(ctrl8),
        .SrcA(a8), .SrcB(b8), .ALUResult(res8), .Zero(zero8),
        .Busy(busy8), .Done(done8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: direct arithmetic on the operand values.
    function automatic logic [31:0] ref32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int sa, sb;
        logic ovf;
        p   = {32'd0, a} * {32'd0, b};
        sa  = $signed(a);
        sb  = $signed(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd6:  return (a < b) ? 32'd1 : 32'd0;
            4'd7:  return a << b[4:0];
            4'd8:  return a >> b[4:0];
            4'd9:  return 32'(sa >>> b[4:0]);
            4'd10: return p[31:0];
            4'd11: return p[63:32];
            4'd12: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
            4'd13: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd14: return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom % 16);
            default: return 32'($urandom);
        endcase
    endfunction

    // One 32-bit operation; a second Start at iteration poke_n and in the Done cycle must be ignored.
    task automatic op32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag, input int poke_n);
        logic [31:0] exp;
        int lat, n, busy_bad;
        exp = ref32(op, a, b);
        lat = (op >= 4'd10) ? 32 : 0;
        @(negedge clk);
        Start = 1'b1; ALUControl = op; SrcA = a; SrcB = b;
        @(posedge clk); #1;
        Start = 1'b0; ALUControl = 4'($urandom); SrcA = $urandom; SrcB = $urandom;
        n = 0; busy_bad = 0;
        while (Done !== 1'b1 && n < 200) begin
            if (Busy !== (lat != 0)) busy_bad++;
            Start = (n == poke_n);
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " latency"}, 64'(n), 64'(lat));
        chk({tag, " result"}, {32'd0, ALUResult}, {32'd0, exp});
        chk({tag, " zero"}, {63'd0, Zero}, {63'd0, exp == 32'd0});
        chk({tag, " busy"}, 64'(busy_bad), 64'd0);
        Start = 1'b1; ALUControl = 4'($urandom_range(0, 9)); SrcA = $urandom; SrcB = $urandom;
        @(posedge clk); #1;
        Start = 1'b0;
        chk({tag, " done pulse"}, {62'd0, Done, Busy}, 64'd0);
        @(posedge clk); #1;
        chk({tag, " hold"}, {31'd0, Done, ALUResult}, {32'd0, exp});
    endtask

    task automatic op8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] exp, input string tag);
        int n;
        @(negedge clk);
        start8 = 1'b1; ctrl8 = op; a8 = a; b8 = b;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        n = 0;
        while (done8 !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " latency8"}, 64'(n), 64'd8);
        chk({tag, " result8"}, {56'd0, res8}, {56'd0, exp});
        @(posedge clk); #1;
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra, rb;
        logic [7:0]  x, y;
        int          p;

        reset = 1'b1; Start = 1'b1; ALUControl = 4'd0; SrcA = 32'd5; SrcB = 32'd9;
        start8 = 1'b1; ctrl8 = 4'd0; a8 = 8'd3; b8 = 8'd4;
        repeat (2) @(posedge clk);
        #1;
        chk("reset state32", {30'd0, Busy, Done, ALUResult}, 64'd0);
        chk("reset zero32", {63'd0, Zero}, 64'd1);
        chk("reset state8", {54'd0, busy8, done8, res8}, 64'd0);
        @(negedge clk);
        reset = 1'b0; Start = 1'b0; start8 = 1'b0;

        op32(4'd1, 32'd5, 32'd7, "sub 5-7", -1);
        op32(4'd1, 32'd7, 32'd7, "sub 7-7", -1);
        op32(4'd9, 32'h8000_0000, 32'h24, "sra", -1);
        op32(4'd6, 32'd1, 32'hFFFF_FFFF, "sltu", -1);
        op32(4'd5, 32'd1, 32'hFFFF_FFFF, "slt", -1);
        op32(4'd7, 32'h0000_00F1, 32'hFFFF_FFE3, "sll", -1);
        op32(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul", -1);
        op32(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu", -1);
        op32(4'd12, 32'hFFFF_FFF9, 32'd2, "div -7/2", -1);
        op32(4'd14, 32'hFFFF_FFF9, 32'd2, "rem -7/2", -1);
        op32(4'd13, 32'd9, 32'd0, "divu 9/0", -1);
        op32(4'd15, 32'd9, 32'd0, "remu 9/0", -1);
        op32(4'd12, 32'hFFFF_FFF9, 32'd0, "div -7/0", -1);
        op32(4'd14, 32'hFFFF_FFF9, 32'd0, "rem -7/0", -1);
        op32(4'd12, 32'h8000_0000, 32'hFFFF_FFFF, "div ovf", -1);
        op32(4'd14, 32'h8000_0000, 32'hFFFF_FFFF, "rem ovf", -1);
        op32(4'd13, 32'd1000, 32'd7, "divu poke", 5);
        op32(4'd10, 32'd123, 32'd456, "mul poke", 20);

        // Reset in the middle of a DIVU, with a coincident Start.
        op32(4'd0, 32'd3, 32'd4, "add pre", -1);
        @(negedge clk);
        Start = 1'b1; ALUControl = 4'd13; SrcA = 32'd100000; SrcB = 32'd3;
        @(posedge clk); #1;
        Start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("mid busy", {63'd0, Busy}, 64'd1);
        reset = 1'b1; Start = 1'b1; ALUControl = 4'd0;
        @(posedge clk); #1;
        reset = 1'b0; Start = 1'b0;
        chk("mid reset state", {30'd0, Busy, Done, ALUResult}, 64'd0);
        chk("mid reset zero", {63'd0, Zero}, 64'd1);
        repeat (40) @(posedge clk);
        #1;
        chk("after reset quiet", {30'd0, Busy, Done, ALUResult}, 64'd0);
        op32(4'd0, 32'hFFFF_FFFF, 32'd2, "add post", -1);

        for (int i = 0; i < 60; i++) begin
            rop = 4'($urandom);
            ra  = pick();
            rb  = pick();
            p   = ($urandom % 4 == 0) ? int'($urandom % 32) : -1;
            op32(rop, ra, rb, "random", p);
        end

        op8(4'd10, 8'h10, 8'h10, 8'h00, "mul8");
        op8(4'd11, 8'h10, 8'h10, 8'h01, "mulhu8");
        op8(4'd12, 8'h80, 8'hFF, 8'h80, "div8 ovf");
        op8(4'd14, 8'hF9, 8'h02, 8'hFF, "rem8");
        for (int i = 0; i < 20; i++) begin
            x = 8'($urandom);
            y = ($urandom % 5 == 0) ? 8'd0 : 8'($urandom);
            case (i % 4)
                0: op8(4'd10, x, y, 8'((int'(x) * int'(y)) % 256), "rmul8");
                1: op8(4'd11, x, y, 8'((int'(x) * int'(y)) / 256), "rmulhu8");
                2: op8(4'd13, x, y, (y == 0) ? 8'hFF : 8'(int'(x) / int'(y)), "rdivu8");
                default: op8(4'd15, x, y, (y == 0) ? x : 8'(int'(x) % int'(y)), "rremu8");
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
